asteroide_uc: RTL

- Control unit (FSM) that drives the asteroid datapath (`asteroide`).
- Consumes the datapath status flags: colisao, rco_contador, opcode, destruido, loaded.
- Produces every datapath control strobe.
- On each `iniciar` pulse it sweeps all asteroid memory slots once: moves each live asteroid by its opcode, writes it back, checks it against the ship and marks it destroyed on collision.

---
 rtl/asteroide_pkg.sv | 40 ++++
 rtl/asteroide_uc_if.sv | 45 ++++
 rtl/asteroide_uc.sv | 98 +++++++++
 3 files changed

// File: rtl/asteroide_pkg.sv
// Shared types and constants for the asteroid control unit.
// State encodings are fixed; the debug port exposes them as-is.
package asteroide_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    ZERA    = 3'd1,
    CARREGA = 3'd2,
    MOVE    = 3'd3,
    COMPARA = 3'd4,
    COLIDE  = 3'd5,
    PROXIMO = 3'd6,
    FIM     = 3'd7
  } estado_t;

  localparam logic [1:0] OP_DIREITA  = 2'b00;
  localparam logic [1:0] OP_ESQUERDA = 2'b01;
  localparam logic [1:0] OP_BAIXO    = 2'b10;
  localparam logic [1:0] OP_CIMA     = 2'b11;

  localparam logic [1:0] MUX_POS_ASTE = 2'b10;
  localparam logic [1:0] MUX_POS_NAVE = 2'b01;

  // Returns {coor, soma_sub}: coor 0 = x, soma_sub 1 = subtract.
  function automatic logic [1:0] decodifica_opcode(
    input logic [1:0] op
  );
    logic [1:0] r;
    r = 2'b00;
    unique case (op)
      OP_DIREITA:  r = 2'b00;
      OP_ESQUERDA: r = 2'b01;
      OP_BAIXO:    r = 2'b10;
      OP_CIMA:     r = 2'b11;
      default:     r = 2'b00;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/asteroide_uc_if.sv
// Control/status bundle between the asteroid FSM and its datapath.
// master = control unit, slave = datapath.
interface asteroide_uc_if;

  logic       colisao;
  logic       rco_contador;
  logic [1:0] opcode;
  logic       destruido;
  logic       loaded;

  logic       conta_contador;
  logic       reset_cont;
  logic [1:0] select_mux_pos;
  logic       select_mux_coor;
  logic       select_soma_sub;
  logic       enable_reg_nave;
  logic       reset_reg_nave;
  logic       enable_mem_aste;
  logic       enable_mem_load;
  logic       new_load;
  logic       new_destruido;

  modport master (
    input  colisao, rco_contador, opcode,
    input  destruido, loaded,
    output conta_contador, reset_cont,
    output select_mux_pos, select_mux_coor,
    output select_soma_sub,
    output enable_reg_nave, reset_reg_nave,
    output enable_mem_aste, enable_mem_load,
    output new_load, new_destruido
  );

  modport slave (
    output colisao, rco_contador, opcode,
    output destruido, loaded,
    input  conta_contador, reset_cont,
    input  select_mux_pos, select_mux_coor,
    input  select_soma_sub,
    input  enable_reg_nave, reset_reg_nave,
    input  enable_mem_aste, enable_mem_load,
    input  new_load, new_destruido
  );

endinterface

// File: rtl/asteroide_uc.sv
// Asteroid sweep control unit: moves, writes back and hit-tests every slot.
// Define ASTEROIDE_UC_DB_EN to expose the state as db_estado.
module asteroide_uc
  import asteroide_pkg::*;
(
  input  logic           clock,
  input  logic           reset_n,
  input  logic           iniciar,
  input  logic           atualiza_nave,
  asteroide_uc_if.master dp,
  output logic           pronto,
  output logic           colisao_detectada
`ifdef ASTEROIDE_UC_DB_EN
  ,
  output logic [2:0]     db_estado
`endif
);

  estado_t estado;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      estado            <= IDLE;
      colisao_detectada <= 1'b0;
    end else begin
      unique case (estado)
        IDLE: begin
          if (iniciar) estado <= ZERA;
        end
        ZERA: begin
          estado            <= CARREGA;
          colisao_detectada <= 1'b0;
        end
        CARREGA: begin
          if (dp.loaded && !dp.destruido)
            estado <= MOVE;
          else
            estado <= PROXIMO;
        end
        MOVE: estado <= COMPARA;
        COMPARA: begin
          if (dp.colisao) estado <= COLIDE;
          else            estado <= PROXIMO;
        end
        COLIDE: begin
          estado            <= PROXIMO;
          colisao_detectada <= 1'b1;
        end
        PROXIMO: begin
          if (dp.rco_contador) estado <= FIM;
          else                 estado <= CARREGA;
        end
        FIM:     estado <= IDLE;
        default: estado <= IDLE;
      endcase
    end
  end

  always_comb begin
    dp.conta_contador  = 1'b0;
    dp.reset_cont      = 1'b0;
    dp.select_mux_pos  = MUX_POS_NAVE;
    dp.select_mux_coor = 1'b0;
    dp.select_soma_sub = 1'b0;
    dp.enable_reg_nave = 1'b0;
    dp.reset_reg_nave  = 1'b0;
    dp.enable_mem_aste = 1'b0;
    dp.enable_mem_load = 1'b0;
    dp.new_load        = 1'b0;
    dp.new_destruido   = 1'b0;
    pronto             = 1'b0;
    unique case (estado)
      IDLE: dp.enable_reg_nave = atualiza_nave;
      ZERA: dp.reset_cont = 1'b1;
      CARREGA: dp.select_mux_pos = MUX_POS_ASTE;
      MOVE: begin
        dp.select_mux_pos  = MUX_POS_ASTE;
        dp.enable_mem_aste = 1'b1;
        {dp.select_mux_coor, dp.select_soma_sub} =
          decodifica_opcode(dp.opcode);
      end
      COMPARA: dp.select_mux_pos = MUX_POS_ASTE;
      COLIDE: begin
        dp.enable_mem_load = 1'b1;
        dp.new_load        = 1'b1;
        dp.new_destruido   = 1'b1;
      end
      PROXIMO: dp.conta_contador = !dp.rco_contador;
      FIM:     pronto = 1'b1;
      default: ;
    endcase
  end

`ifdef ASTEROIDE_UC_DB_EN
  assign db_estado = estado;
`endif

endmodule
